// File: rtl/udp_stream_sender.sv
// udp_stream_sender: buffers a 32-bit valid/ready stream in a FIFO and
// frames it as UDP packets on the UPL output bus. The header is SRC_IP,
// DST_IP, ports, byte count and an optional sequence word, followed by the
// payload. A packet launches on MAX_WORDS buffered words or on an idle timeout.
module udp_stream_sender #(
  parameter int FIFO_AW        = 7,
  parameter int MAX_WORDS      = 64,
  parameter int TIMEOUT_CYCLES = 125000000,
  parameter int SEQ_EN         = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        UPLout_Reqeust,
  input  logic        UPLout_Ack,
  output logic        UPLout_Enable,
  output logic [31:0] UPLout_Data,
  input  logic [31:0] SRC_IP,
  input  logic [31:0] DST_IP,
  input  logic [15:0] SRC_PORT,
  input  logic [15:0] DST_PORT,
  output logic [31:0] pkt_count,
  output logic        busy
);
  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int CW      = FIFO_AW + 1;
  localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HDR_LEN = 4 + SEQ_EN;
  localparam logic [CW-1:0] MAXW = CW'(MAX_WORDS);
  localparam logic [TW-1:0] TMO  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, REQ, HDR, DATA} state_t;

  state_t state, state_nxt;

  // FIFO storage and bookkeeping
  logic [31:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]      count, count_nxt;
  logic               wr_en, rd_en;

  // Launch / timer
  logic [TW-1:0] timer;
  logic          launch;
  logic [CW-1:0] n_sel;

  // Per-packet latched context
  logic [CW-1:0] n_words;
  logic [31:0]   bytes_q, src_q, dst_q, ports_q, seq;
  logic [2:0]    hdr_idx;
  logic [CW-1:0] wcnt;
  logic          hdr_last, last_word;

  assign wr_en     = s_valid & s_ready;
  assign count_nxt = count + CW'(wr_en) - CW'(rd_en);
  assign launch    = (state == IDLE) &&
                     ((count >= MAXW) || ((count != '0) && (timer == TMO)));
  assign n_sel     = (count >= MAXW) ? MAXW : count;
  assign hdr_last  = (state == HDR) && (hdr_idx == 3'(HDR_LEN - 1));
  assign last_word = (state == DATA) && (wcnt == n_words - CW'(1));

  // FIFO write port (storage needs no reset; pointers do)
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= s_data;
  end

  // FIFO pointers, occupancy and registered ready (from next-cycle fullness)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      s_ready <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count   <= count_nxt;
      s_ready <= (count_nxt != CW'(DEPTH));
    end
  end

  // Idle timer: counts partial-fill cycles in IDLE, saturates at the timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (launch || count == '0) begin
      timer <= '0;
    end else if (state == IDLE && count < MAXW && timer != TMO) begin
      timer <= timer + 1'b1;
    end
  end

  // Capture packet length and addressing at launch so later changes don't tear a packet
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_words <= '0;
      bytes_q <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      ports_q <= '0;
    end else if (launch) begin
      n_words <= n_sel;
      bytes_q <= (32'(n_sel) + 32'(SEQ_EN)) << 2;
      src_q   <= SRC_IP;
      dst_q   <= DST_IP;
      ports_q <= {SRC_PORT, DST_PORT};
    end
  end

  // Header and payload position counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_idx <= '0;
      wcnt    <= '0;
    end else begin
      hdr_idx <= (state == HDR)  ? hdr_idx + 1'b1 : '0;
      wcnt    <= (state == DATA) ? wcnt + 1'b1    : '0;
    end
  end

  // Packet and sequence counters advance as the last payload word leaves
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count <= '0;
      seq       <= '0;
    end else if (last_word) begin
      pkt_count <= pkt_count + 1'b1;
      seq       <= seq + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; Ack only matters while requesting
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (launch)     state_nxt = REQ;
      REQ:     if (UPLout_Ack) state_nxt = HDR;
      HDR:     if (hdr_last)   state_nxt = DATA;
      DATA:    if (last_word)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Output decode; data bus is forced to zero whenever Enable is low
  always_comb begin
    UPLout_Reqeust = (state == REQ);
    UPLout_Enable  = (state == HDR) || (state == DATA);
    rd_en          = (state == DATA);
    busy           = (state != IDLE);
    UPLout_Data    = '0;
    if (state == HDR) begin
      case (hdr_idx)
        3'd0:    UPLout_Data = src_q;
        3'd1:    UPLout_Data = dst_q;
        3'd2:    UPLout_Data = ports_q;
        3'd3:    UPLout_Data = bytes_q;
        default: UPLout_Data = seq;
      endcase
    end else if (state == DATA) begin
      UPLout_Data = mem[rd_ptr];
    end
  end
endmodule

// File: tb/tb_udp_stream_sender.sv
// Directed bench for udp_stream_sender. DUT A (depth 8, 4-word packets,
// 16-cycle timeout, sequence word on) covers framing, timeout, FIFO full,
// streaming across packets and mid-packet reset. DUT B (1-word packets,
// no sequence word) covers the minimal packet.
module tb_udp_stream_sender;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // DUT A signals
  logic [31:0] a_sdata = '0, a_dout, a_pkt, a_src = 32'hC0A80001, a_dst = 32'hC0A80002;
  logic        a_valid = 1'b0, a_ready, a_req, a_ack = 1'b0, a_en, a_busy;
  logic [15:0] a_sp = 16'h1234, a_dp = 16'h5678;
  // DUT B signals
  logic [31:0] b_sdata = '0, b_dout, b_pkt, b_src = 32'h0A000001, b_dst = 32'h0A000002;
  logic        b_valid = 1'b0, b_ready, b_req, b_ack = 1'b0, b_en, b_busy;
  logic [15:0] b_sp = 16'h0400, b_dp = 16'h0401;

  udp_stream_sender #(.FIFO_AW(3), .MAX_WORDS(4), .TIMEOUT_CYCLES(16), .SEQ_EN(1)) dut_a (
    .clk(clk), .reset(reset), .s_data(a_sdata), .s_valid(a_valid), .s_ready(a_ready),
    .UPLout_Reqeust(a_req), .UPLout_Ack(a_ack), .UPLout_Enable(a_en), .UPLout_Data(a_dout),
    .SRC_IP(a_src), .DST_IP(a_dst), .SRC_PORT(a_sp), .DST_PORT(a_dp),
    .pkt_count(a_pkt), .busy(a_busy));

  udp_stream_sender #(.FIFO_AW(3), .MAX_WORDS(1), .TIMEOUT_CYCLES(16), .SEQ_EN(0)) dut_b (
    .clk(clk), .reset(reset), .s_data(b_sdata), .s_valid(b_valid), .s_ready(b_ready),
    .UPLout_Reqeust(b_req), .UPLout_Ack(b_ack), .UPLout_Enable(b_en), .UPLout_Data(b_dout),
    .SRC_IP(b_src), .DST_IP(b_dst), .SRC_PORT(b_sp), .DST_PORT(b_dp),
    .pkt_count(b_pkt), .busy(b_busy));

  // Bus monitor: captured words, Enable run lengths, protocol violations
  logic [31:0] cap_a[$], cap_b[$];
  int runs_a[$], runs_b[$];
  int run_a = 0, run_b = 0, zbad = 0, ovl = 0;

  always @(negedge clk) begin
    if (a_en) begin cap_a.push_back(a_dout); run_a++; end
    else begin
      if (run_a != 0) runs_a.push_back(run_a);
      run_a = 0;
      if (a_dout != 0) zbad++;
    end
    if (b_en) begin cap_b.push_back(b_dout); run_b++; end
    else begin
      if (run_b != 0) runs_b.push_back(run_b);
      run_b = 0;
      if (b_dout != 0) zbad++;
    end
    if ((a_en && a_req) || (b_en && b_req)) ovl++;
  end

  // Present one word and hold it until accepted (caller sits on a negedge)
  task automatic push(input int dut, input logic [31:0] w);
    int t = 0;
    if (dut == 0) begin
      a_valid = 1'b1; a_sdata = w;
      while (!a_ready && t < 200) begin @(negedge clk); t++; end
    end else begin
      b_valid = 1'b1; b_sdata = w;
      while (!b_ready && t < 200) begin @(negedge clk); t++; end
    end
    if (t >= 200) begin
      tests++; fails++;
      $display("FAIL push_timeout dut=%0d word=%h never accepted", dut, w);
    end
    @(negedge clk);
  endtask

  // Wait for Request, grant after dly cycles, then wait for the packet to end
  task automatic do_packet(input int dut, input int dly);
    int t = 0;
    while (!(dut == 0 ? a_req : b_req) && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin
      tests++; fails++;
      $display("FAIL req_timeout dut=%0d no Request within 200 cycles", dut);
      return;
    end
    repeat (dly) @(negedge clk);
    if (dut == 0) a_ack = 1'b1; else b_ack = 1'b1;
    @(negedge clk);
    a_ack = 1'b0; b_ack = 1'b0;
    t = 0;
    while ((dut == 0 ? a_busy : b_busy) && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) begin
      tests++; fails++;
      $display("FAIL pkt_timeout dut=%0d packet never completed", dut);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests++;
    if ({a_ready, a_req, a_en, a_busy} !== 4'b0 || a_dout !== 32'd0 || a_pkt !== 32'd0) begin
      fails++;
      $display("FAIL reset_state got rdy=%b req=%b en=%b busy=%b data=%h pkt=%0d exp all 0",
               a_ready, a_req, a_en, a_busy, a_dout, a_pkt);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_reset got a=%b b=%b exp 1", a_ready, b_ready);
    end
  endtask

  // T1: four words, Ack two cycles after Request
  task automatic test_full_packet;
    logic [31:0] exp[9];
    exp = '{32'hC0A80001, 32'hC0A80002, 32'h12345678, 32'h14, 32'h0,
            32'hA, 32'hB, 32'hC, 32'hD};
    for (int i = 0; i < 4; i++) push(0, 32'hA + i);
    a_valid = 1'b0;
    do_packet(0, 2);
    tests++;
    if (cap_a.size() != 9) begin
      fails++;
      $display("FAIL t1_len got %0d words exp 9", cap_a.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        tests++;
        if (cap_a[i] !== exp[i]) begin
          fails++;
          $display("FAIL t1_word%0d got %h exp %h", i, cap_a[i], exp[i]);
        end
      end
    end
    tests++;
    if (runs_a.size() != 1 || runs_a[0] != 9) begin
      fails++;
      $display("FAIL t1_contiguous got %0d runs first=%0d exp 1 run of 9",
               runs_a.size(), runs_a.size() > 0 ? runs_a[0] : 0);
    end
    tests++;
    if (a_pkt !== 32'd1) begin
      fails++;
      $display("FAIL t1_pkt_count got %0d exp 1", a_pkt);
    end
  endtask

  // T2: single word flushed by the idle timeout; config latched at launch
  task automatic test_timeout;
    int first = 0;
    cap_a.delete(); runs_a.delete();
    push(0, 32'hE0E0E0E0);
    a_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (a_req && first == 0) first = i;
    end
    tests++;
    if (first != 17) begin
      fails++;
      $display("FAIL t2_req_cycle got %0d exp 17 cycles after write edge", first);
    end
    a_src = 32'hDEADBEEF;
    do_packet(0, 0);
    tests++;
    if (cap_a.size() != 6 || cap_a[0] !== 32'hC0A80001 || cap_a[3] !== 32'd8 ||
        cap_a[4] !== 32'd1 || cap_a[5] !== 32'hE0E0E0E0) begin
      fails++;
      $display("FAIL t2_packet got n=%0d src=%h bytes=%h seq=%h pay=%h exp 6 c0a80001 8 1 e0e0e0e0",
               cap_a.size(), cap_a[0], cap_a[3], cap_a[4], cap_a[5]);
    end
    tests++;
    if (a_pkt !== 32'd2) begin
      fails++;
      $display("FAIL t2_pkt_count got %0d exp 2", a_pkt);
    end
    a_src = 32'hC0A80001;
  endtask

  // T3: fill the FIFO while the grant is withheld
  task automatic test_fifo_full;
    int nacc = 0;
    bit acc;
    logic [31:0] d = 32'h300;
    cap_a.delete(); runs_a.delete();
    a_valid = 1'b1; a_sdata = d;
    for (int i = 0; i < 20; i++) begin
      acc = a_ready;
      @(negedge clk);
      if (acc) begin nacc++; d++; a_sdata = d; end
    end
    a_valid = 1'b0;
    tests++;
    if (nacc != 8 || a_ready !== 1'b0) begin
      fails++;
      $display("FAIL t3_full got accepted=%0d ready=%b exp 8 0", nacc, a_ready);
    end
    do_packet(0, 0);
    do_packet(0, 0);
    tests++;
    if (cap_a.size() != 18) begin
      fails++;
      $display("FAIL t3_len got %0d exp 18", cap_a.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests++;
        if (cap_a[(i / 4) * 9 + 5 + (i % 4)] !== 32'h300 + i) begin
          fails++;
          $display("FAIL t3_order%0d got %h exp %h", i, cap_a[(i / 4) * 9 + 5 + (i % 4)], 32'h300 + i);
        end
      end
      tests++;
      if (cap_a[3] !== 32'h14 || cap_a[13] !== 32'd3) begin
        fails++;
        $display("FAIL t3_hdr got bytes=%h seq2=%h exp 14 3", cap_a[3], cap_a[13]);
      end
    end
  endtask

  // T4: continuous stream while packets drain
  task automatic test_back_to_back;
    int npk = 0, got = 0, idx = 0, n;
    bit ok = 1;
    logic [31:0] exp_seq = 32'd4;
    cap_a.delete(); runs_a.delete();
    fork
      begin
        for (int k = 0; k < 12; k++) push(0, 32'h400 + k);
        a_valid = 1'b0;
      end
      begin
        while (npk < 8 && (cap_a.size() - 5 * npk) < 12) begin
          do_packet(0, 1);
          npk++;
        end
      end
    join
    while (idx + 4 < cap_a.size()) begin
      n = int'(cap_a[idx + 3] / 4) - 1;
      if (cap_a[idx + 4] !== exp_seq) ok = 0;
      exp_seq++;
      for (int j = 0; j < n && idx + 5 + j < cap_a.size(); j++) begin
        if (cap_a[idx + 5 + j] !== 32'h400 + got) ok = 0;
        got++;
      end
      idx += 5 + n;
    end
    tests++;
    if (got != 12 || !ok) begin
      fails++;
      $display("FAIL t4_stream got %0d payload words order_ok=%0d exp 12 1", got, ok);
    end
    tests++;
    if (zbad != 0 || ovl != 0) begin
      fails++;
      $display("FAIL bus_rules got data_nonzero_idle=%0d req_during_en=%0d exp 0 0", zbad, ovl);
    end
  endtask

  // T5: reset in the middle of the payload
  task automatic test_reset_mid;
    int t = 0;
    for (int i = 0; i < 4; i++) push(0, 32'h500 + i);
    a_valid = 1'b0;
    while (!a_req && t < 100) begin @(negedge clk); t++; end
    a_ack = 1'b1;
    @(negedge clk);
    a_ack = 1'b0;
    repeat (6) @(negedge clk);
    tests++;
    if (a_en !== 1'b1) begin
      fails++;
      $display("FAIL t5_in_data got en=%b exp 1", a_en);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (a_en !== 1'b0 || a_dout !== 32'd0 || a_ready !== 1'b0 || a_busy !== 1'b0 || a_pkt !== 32'd0) begin
      fails++;
      $display("FAIL t5_reset_now got en=%b data=%h rdy=%b busy=%b pkt=%0d exp 0",
               a_en, a_dout, a_ready, a_busy, a_pkt);
    end
    @(negedge clk);
    tests++;
    if (a_ready !== 1'b0) begin
      fails++;
      $display("FAIL t5_ready_in_reset got %b exp 0", a_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    cap_a.delete(); runs_a.delete();
    for (int i = 0; i < 4; i++) push(0, 32'h600 + i);
    a_valid = 1'b0;
    do_packet(0, 0);
    tests++;
    if (cap_a.size() != 9 || cap_a[4] !== 32'd0 || cap_a[5] !== 32'h600 || cap_a[6] !== 32'h601 ||
        cap_a[7] !== 32'h602 || cap_a[8] !== 32'h603 || a_pkt !== 32'd1) begin
      fails++;
      $display("FAIL t5_restart got n=%0d seq=%h first=%h last=%h pkt=%0d exp 9 0 600 603 1",
               cap_a.size(), cap_a[4], cap_a[5], cap_a[8], a_pkt);
    end
  endtask

  // T6: one-word packets without sequence word
  task automatic test_single_word;
    logic [31:0] exp[10];
    exp = '{32'h0A000001, 32'h0A000002, 32'h04000401, 32'd4, 32'h700,
            32'h0A000001, 32'h0A000002, 32'h04000401, 32'd4, 32'h701};
    cap_b.delete(); runs_b.delete();
    push(1, 32'h700);
    push(1, 32'h701);
    b_valid = 1'b0;
    do_packet(1, 0);
    do_packet(1, 0);
    tests++;
    if (cap_b.size() != 10) begin
      fails++;
      $display("FAIL t6_len got %0d exp 10", cap_b.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        tests++;
        if (cap_b[i] !== exp[i]) begin
          fails++;
          $display("FAIL t6_word%0d got %h exp %h", i, cap_b[i], exp[i]);
        end
      end
    end
    tests++;
    if (runs_b.size() != 2 || runs_b[0] != 5 || runs_b[1] != 5 || b_pkt !== 32'd2) begin
      fails++;
      $display("FAIL t6_runs got runs=%0d pkt=%0d exp 2 runs of 5, pkt 2", runs_b.size(), b_pkt);
    end
  endtask

  initial begin
    test_reset();
    test_full_packet();
    test_timeout();
    test_fifo_full();
    test_back_to_back();
    test_reset_mid();
    test_single_word();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
